// File: rtl/db15_serial_responder_if.sv
// JOY_CLK/JOY_LOAD/JOY_DATA link between a joy_db15 receiver (master) and the SNAC-style responder (slave).
interface db15_serial_responder_if;
    logic JOY_CLK;
    logic JOY_LOAD;
    logic JOY_DATA;

    modport master (output JOY_CLK, output JOY_LOAD, input JOY_DATA);
    modport slave  (input JOY_CLK, input JOY_LOAD, output JOY_DATA);
endinterface

// File: rtl/db15_serial_responder.sv
// Far-end emulation of a two-player DB15 parallel-in/serial-out chain: filtered JOY_LOAD/JOY_CLK
// capture two active-high pad words and shift them out active-low, player 1 MSB first.
module db15_serial_responder #(
    parameter int NBITS       = 12,
    parameter int SYNC_STAGES = 2,
    parameter int FILT        = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NBITS-1:0]     joy_p1,
    input  logic [NBITS-1:0]     joy_p2,
    db15_serial_responder_if.slave joyIf,
    output logic                 frame_done,
    output logic                 busy
);
    localparam int FRAME = 2 * NBITS;
    localparam int CW    = $clog2(FRAME);
    localparam int FCW   = (FILT > 1) ? $clog2(FILT) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] r_clkSync;
    logic [SYNC_STAGES-1:0] r_loadSync;
    logic                   r_clkFilt;
    logic                   r_loadFilt;
    logic [FCW-1:0]         r_clkFcnt;
    logic [FCW-1:0]         r_loadFcnt;

    logic                   w_clkSync;
    logic                   w_loadSync;
    logic                   w_clkAccept;
    logic                   w_loadAccept;
    logic                   w_clkRise;
    logic                   w_loadFall;
    logic                   w_loadRise;

    state_t                 r_state;
    state_t                 w_stateNext;
    logic [FRAME-1:0]       r_sreg;
    logic [FRAME-1:0]       w_sregNext;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cntNext;
    logic                   r_busy;
    logic                   w_busyNext;
    logic                   r_done;
    logic                   w_doneNext;
    logic [FRAME-1:0]       w_snapshot;
    logic [FRAME-1:0]       w_shifted;

    // Idle levels: LOAD released (high), CLK low, so reset never fakes a load edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clkSync  <= '0;
            r_loadSync <= '1;
        end else begin
            r_clkSync  <= {r_clkSync[SYNC_STAGES-2:0], joyIf.JOY_CLK};
            r_loadSync <= {r_loadSync[SYNC_STAGES-2:0], joyIf.JOY_LOAD};
        end
    end

    assign w_clkSync    = r_clkSync[SYNC_STAGES-1];
    assign w_loadSync   = r_loadSync[SYNC_STAGES-1];
    assign w_clkAccept  = (w_clkSync != r_clkFilt) && (r_clkFcnt == FCW'(FILT - 1));
    assign w_loadAccept = (w_loadSync != r_loadFilt) && (r_loadFcnt == FCW'(FILT - 1));
    assign w_clkRise    = w_clkAccept && w_clkSync;
    assign w_loadFall   = w_loadAccept && !w_loadSync;
    assign w_loadRise   = w_loadAccept && w_loadSync;

    // A new level is adopted only after FILT consecutive cycles of disagreement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clkFilt  <= 1'b0;
            r_clkFcnt  <= '0;
            r_loadFilt <= 1'b1;
            r_loadFcnt <= '0;
        end else begin
            if (w_clkSync == r_clkFilt) begin
                r_clkFcnt <= '0;
            end else if (w_clkAccept) begin
                r_clkFilt <= w_clkSync;
                r_clkFcnt <= '0;
            end else begin
                r_clkFcnt <= r_clkFcnt + FCW'(1);
            end

            if (w_loadSync == r_loadFilt) begin
                r_loadFcnt <= '0;
            end else if (w_loadAccept) begin
                r_loadFilt <= w_loadSync;
                r_loadFcnt <= '0;
            end else begin
                r_loadFcnt <= r_loadFcnt + FCW'(1);
            end
        end
    end

    assign w_snapshot = ~{joy_p1, joy_p2};
    assign w_shifted  = {r_sreg[FRAME-2:0], 1'b1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_sreg  <= '1;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_sreg  <= w_sregNext;
            r_cnt   <= w_cntNext;
            r_busy  <= w_busyNext;
            r_done  <= w_doneNext;
        end
    end

    // Load edges are checked before clock edges, so a coincident load always wins.
    always_comb begin
        w_stateNext = r_state;
        w_sregNext  = r_sreg;
        w_cntNext   = r_cnt;
        w_busyNext  = r_busy;
        w_doneNext  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_loadFall) begin
                    w_sregNext  = w_snapshot;
                    w_cntNext   = '0;
                    w_busyNext  = 1'b1;
                    w_stateNext = LOAD;
                end else if (w_clkRise) begin
                    w_sregNext = w_shifted;
                end
            end
            LOAD: begin
                w_sregNext = w_snapshot;
                if (w_loadRise) begin
                    w_stateNext = SHIFT;
                end
            end
            SHIFT: begin
                if (w_loadFall) begin
                    w_sregNext  = w_snapshot;
                    w_cntNext   = '0;
                    w_stateNext = LOAD;
                end else if (w_clkRise) begin
                    w_sregNext = w_shifted;
                    if (r_cnt == CW'(FRAME - 1)) begin
                        w_cntNext   = '0;
                        w_doneNext  = 1'b1;
                        w_busyNext  = 1'b0;
                        w_stateNext = IDLE;
                    end else begin
                        w_cntNext = r_cnt + CW'(1);
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign joyIf.JOY_DATA = r_sreg[FRAME-1];
    assign frame_done     = r_done;
    assign busy           = r_busy;
endmodule
